datapath_mc: RTL
================

Name: datapath_mc

Overview:
- Parametrised multi-cycle successor of the 8-bit single-cycle datapath.
- Holds its own program memory (DEPTH x WIDTH), a register file (NREGS x WIDTH), an ALU with flags, a PC and a control FSM.
- Sequences fetch/execute itself instead of relying on external load strobes; supports branches, immediate loads and halt.
- Sits between the board-level loader/top and the processor I/O.

Parameters:
- WIDTH, 8, data/instruction word width in bits (>=8).
- DEPTH, 64, program memory words; ADDR_W = clog2(DEPTH).
- NREGS, 8, register file entries; RSEL_W = clog2(NREGS).

Ports:
- clock  in  1  single system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write load_data to memory[load_addr]; honoured only in IDLE.
- load_addr  in  ADDR_W  program load address.
- load_data  in  WIDTH  program load word.
- start  in  1  one-cycle pulse, IDLE -> FETCH with PC=0.
- busy  out  1  high in FETCH/EXEC.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set when an undefined opcode is executed.
- result  out  WIDTH  last value written to a register.
- flags  out  4  {V,S,C,Z}.
- pc_out  out  ADDR_W  current PC.

Behaviour:
- Reset, checked every cycle, overrides everything including mid-instruction:
  - state=IDLE, PC=0; all registers, result, flags and illegal = 0.
  - Memory contents are not cleared.
- Instruction format: 3 words at PC, PC+1, PC+2 (opcode, a, b). Addresses wrap mod DEPTH. Register index = low RSEL_W bits of a or b.
- FSM:
  - IDLE: loads accepted; start -> FETCH. start and load_en in the same cycle: the write happens and the FSM moves to FETCH.
  - FETCH (1 cycle): latch opcode/a/b into IR from asynchronous memory reads -> EXEC.
  - EXEC (1 cycle): execute, update PC/regs/flags -> FETCH; HALT opcode or illegal -> HALT.
  - HALT: holds all state; start -> FETCH with PC=0 (illegal stays set until reset); load_en ignored.
- Throughput: 2 cycles per instruction. A register write is visible to the next instruction's EXEC.
- Opcodes (low byte of opcode word; upper bits ignored):
  - 0x00 NOP.
  - 0x01 LDI r[a]=b.
  - 0x02 ADD r[a]=r[a]+r[b].
  - 0x03 SUB r[a]=r[a]-r[b].
  - 0x04 AND; 0x05 OR; 0x06 XOR (r[a] = r[a] op r[b]).
  - 0x07 MOV r[a]=r[b].
  - 0x08 JMP PC=a.
  - 0x09 JZ, if Z: PC=a, else PC+3.
  - 0x0A JC, same rule on C.
  - 0xFF HALT.
  - Any other value: illegal -> HALT with illegal=1.
- PC: non-branch instructions advance PC by 3 mod DEPTH. Jump targets use the low ADDR_W bits of a.
- Flags:
  - Updated only by ADD/SUB/AND/OR/XOR; LDI/MOV/branches leave flags unchanged.
  - Z = (res==0); S = res[WIDTH-1].
  - ADD: C = carry out of bit WIDTH-1; V = signed overflow.
  - SUB: C = borrow (r[a] < r[b] unsigned); V = signed overflow.
  - Logic ops: C=V=0.
- result updates on every register write (LDI/MOV/ALU).
- Loads while not IDLE are dropped, with no side effect.

Test Plan:
- Reset/idle: assert reset mid-EXEC of an ADD -> next cycle busy=0, pc_out=0, result=0, flags=0; memory retains the program.
- ADD overflow (WIDTH=8): load LDI r0,0x7F; LDI r1,0x01; ADD r0,r1; HALT; pulse start -> halted after 8 cycles, result=0x80, flags V=1,S=1,C=0,Z=0.
- SUB borrow/zero:
  - LDI r2,5; LDI r3,5; SUB r2,r3 -> result=0, Z=1, C=0.
  - Then SUB r2,r3 again -> result=0xFB, C=1, S=1.
- Branch loop: LDI r0,3; LDI r1,1; SUB r0,r1; JZ 15; JMP 6; ...; HALT at 15 -> halts with r0=0, pc_out=15, 3 loop iterations.
- Wrap and illegal (DEPTH=64): an instruction at 63 fetches operands from 0 and 1; PC becomes 2. Opcode 0x42 -> halted=1, illegal=1; start restarts at 0 with illegal still 1.
- Load gating: load_en while busy -> memory unchanged. load_en together with start in IDLE -> word written and execution begins.

Source files
------------

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: self-sequenced fetch/execute over an internal program memory,
// register file and flag-producing ALU. Instructions are three words: opcode, a, b.
module datapath_mc #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned NREGS  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned RSEL_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              start,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [WIDTH-1:0]  result,
  output logic [3:0]        flags,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [7:0] OpNop  = 8'h00;
  localparam logic [7:0] OpLdi  = 8'h01;
  localparam logic [7:0] OpAdd  = 8'h02;
  localparam logic [7:0] OpSub  = 8'h03;
  localparam logic [7:0] OpAnd  = 8'h04;
  localparam logic [7:0] OpOr   = 8'h05;
  localparam logic [7:0] OpXor  = 8'h06;
  localparam logic [7:0] OpMov  = 8'h07;
  localparam logic [7:0] OpJmp  = 8'h08;
  localparam logic [7:0] OpJz   = 8'h09;
  localparam logic [7:0] OpJc   = 8'h0A;
  localparam logic [7:0] OpHalt = 8'hFF;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [WIDTH-1:0]   ir_op_q, ir_a_q, ir_b_q;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags_q;
  logic               illegal_q;

  // PC arithmetic wraps modulo DEPTH, which need not be a power of two.
  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] base,
                                                 input int unsigned k);
    logic [ADDR_W:0] s;
    s = {1'b0, base} + (ADDR_W+1)'(k);
    if (s >= (ADDR_W+1)'(DEPTH)) s = s - (ADDR_W+1)'(DEPTH);
    return s[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clock) begin
    if (load_en && state_q == StIdle) mem[load_addr] <= load_data;
  end

  logic [7:0]        opc;
  logic [WIDTH-1:0]  ra, rb, wdata;
  logic [WIDTH:0]    sum, diff;
  logic              reg_we, flag_we, is_halt, is_bad, alu_c, alu_v;
  logic [ADDR_W-1:0] pc_seq, pc_nxt;

  always_comb begin
    opc     = ir_op_q[7:0];
    ra      = regs_q[ir_a_q[RSEL_W-1:0]];
    rb      = regs_q[ir_b_q[RSEL_W-1:0]];
    sum     = {1'b0, ra} + {1'b0, rb};
    diff    = {1'b0, ra} - {1'b0, rb};
    pc_seq  = addr_add(pc_q, 3);
    pc_nxt  = pc_seq;
    wdata   = '0;
    reg_we  = 1'b0;
    flag_we = 1'b0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    is_halt = 1'b0;
    is_bad  = 1'b0;
    unique case (opc)
      OpNop: ;
      OpLdi: begin wdata = ir_b_q; reg_we = 1'b1; end
      OpAdd: begin
        wdata = sum[WIDTH-1:0]; reg_we = 1'b1; flag_we = 1'b1;
        alu_c = sum[WIDTH];
        alu_v = (ra[WIDTH-1] == rb[WIDTH-1]) && (sum[WIDTH-1] != ra[WIDTH-1]);
      end
      OpSub: begin
        wdata = diff[WIDTH-1:0]; reg_we = 1'b1; flag_we = 1'b1;
        alu_c = diff[WIDTH];  // borrow
        alu_v = (ra[WIDTH-1] != rb[WIDTH-1]) && (diff[WIDTH-1] != ra[WIDTH-1]);
      end
      OpAnd: begin wdata = ra & rb; reg_we = 1'b1; flag_we = 1'b1; end
      OpOr:  begin wdata = ra | rb; reg_we = 1'b1; flag_we = 1'b1; end
      OpXor: begin wdata = ra ^ rb; reg_we = 1'b1; flag_we = 1'b1; end
      OpMov: begin wdata = rb; reg_we = 1'b1; end
      OpJmp: pc_nxt = ir_a_q[ADDR_W-1:0];
      OpJz:  if (flags_q[0]) pc_nxt = ir_a_q[ADDR_W-1:0];
      OpJc:  if (flags_q[1]) pc_nxt = ir_a_q[ADDR_W-1:0];
      OpHalt: is_halt = 1'b1;
      default: is_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_op_q   <= '0;
      ir_a_q    <= '0;
      ir_b_q    <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle, StHalt: begin
          if (start) begin
            state_q <= StFetch;
            pc_q    <= '0;
          end
        end
        StFetch: begin
          ir_op_q <= mem[pc_q];
          ir_a_q  <= mem[addr_add(pc_q, 1)];
          ir_b_q  <= mem[addr_add(pc_q, 2)];
          state_q <= StExec;
        end
        StExec: begin
          if (is_halt || is_bad) begin
            // PC is left on the halting instruction.
            state_q   <= StHalt;
            illegal_q <= illegal_q | is_bad;
          end else begin
            pc_q    <= pc_nxt;
            state_q <= StFetch;
            if (reg_we) begin
              regs_q[ir_a_q[RSEL_W-1:0]] <= wdata;
              result_q                   <= wdata;
            end
            if (flag_we) flags_q <= {alu_v, wdata[WIDTH-1], alu_c, (wdata == '0)};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q == StFetch) || (state_q == StExec);
  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;
  assign result  = result_q;
  assign flags   = flags_q;
  assign pc_out  = pc_q;

endmodule
